// File: rtl/lsu_bus_master.sv
// Load/store unit: turns one decoded memory request into AXI4-Lite-style
// read or write transactions, extending loads and building store strobes.
module lsu_bus_master #(
  parameter int ISA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [ISA_WIDTH-1:0] addr,
  input  logic [ISA_WIDTH-1:0] st_data,
  output logic                 done,
  output logic                 err,
  output logic [ISA_WIDTH-1:0] mem_r,
  output logic [ISA_WIDTH-1:0] araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [ISA_WIDTH-1:0] rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [ISA_WIDTH-1:0] awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [ISA_WIDTH-1:0] wdata,
  output logic [3:0]           wstrb,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready
);

  typedef enum logic [2:0] {IDLE, AR, R, W, B, FIN} state_t;

  state_t               state, state_next;
  logic [ISA_WIDTH-1:0] addr_q, st_data_q;
  logic [2:0]           funct3_q;
  logic                 aw_done, w_done;
  logic                 fault, accept;
  logic [1:0]           off;
  logic [ISA_WIDTH-1:0] rdata_shift, load_ext;
  logic [3:0]           strb_base;

  assign accept = req_valid && (state == IDLE);
  assign off    = addr_q[1:0];

  // Requests that must never reach the bus: bad kind, bad size, misaligned.
  always_comb begin
    fault = 1'b0;
    if (is_load == is_store) begin
      fault = 1'b1;
    end else if (is_load) begin
      if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) fault = 1'b1;
    end else if (funct3 > 3'b010) begin
      fault = 1'b1;
    end
    if (funct3[1:0] == 2'b01 && addr[0]) fault = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) fault = 1'b1;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (fault)        state_next = FIN;
          else if (is_load) state_next = AR;
          else              state_next = W;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_next = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_next = FIN;
      end
      W: begin
        // AW and W retire independently; leave once both have been taken.
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_next = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata_shift = rdata >> {off, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{(ISA_WIDTH-8){rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_ext = {{(ISA_WIDTH-16){rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_ext = {{(ISA_WIDTH-8){1'b0}}, rdata_shift[7:0]};
      3'b101:  load_ext = {{(ISA_WIDTH-16){1'b0}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  assign araddr = {addr_q[ISA_WIDTH-1:2], 2'b00};
  assign awaddr = {addr_q[ISA_WIDTH-1:2], 2'b00};
  assign wdata  = st_data_q << {off, 3'b000};
  assign wstrb  = strb_base << off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      st_data_q <= '0;
      funct3_q  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      err       <= 1'b0;
      mem_r     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q    <= addr;
        st_data_q <= st_data;
        funct3_q  <= funct3;
        err       <= fault;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
      // Errored loads still commit their (garbage) data to mem_r.
      if (rready && rvalid) begin
        mem_r <= load_ext;
        if (rresp != 2'b00) err <= 1'b1;
      end
      if (bready && bvalid && bresp != 2'b00) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: vector table driven through a
// delay-configurable slave, with a scoreboard checked on bus activity and done.
`timescale 1ns/1ps
module tb_lsu_bus_master;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic        done, err;
  logic [31:0] mem_r;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  lsu_bus_master #(.ISA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .st_data(st_data),
    .done(done), .err(err), .mem_r(mem_r),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, sd, rd;
    logic [1:0]  rr, br;
    int          ar_d, r_d, aw_d, w_d, b_d;
    logic [31:0] exp_mem;
    logic        exp_err;
    int          exp_lat;   // done at T+exp_lat; 0 = not checked
    int          exp_bus;   // 0 none, 1 read, 2 write
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  typedef struct {
    logic [31:0] mem;
    logic        err;
    int          lat;
    int          bus;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  int          checks, errors, cyc, accept_cyc;
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [31:0] rdata_val;
  logic [1:0]  rresp_val, bresp_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkValue(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
      input logic [1:0] rr, input logic [1:0] br, input int ard, input int rdl,
      input int awd, input int wdl, input int bdl, input logic [31:0] em,
      input logic ee, input int el, input int eb, input logic [31:0] ea,
      input logic [31:0] ew, input logic [3:0] es);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd;
    v.rr = rr; v.br = br; v.ar_d = ard; v.r_d = rdl; v.aw_d = awd;
    v.w_d = wdl; v.b_d = bdl; v.exp_mem = em; v.exp_err = ee;
    v.exp_lat = el; v.exp_bus = eb; v.exp_addr = ea; v.exp_wdata = ew;
    v.exp_wstrb = es;
    return v;
  endfunction

  // Slave: each ready/valid rises after its configured number of waiting cycles.
  initial begin : slave
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge clk);
      rdata = rdata_val; rresp = rresp_val; bresp = bresp_val;
      if (!arvalid) begin arready = 0; ar_c = 0; end
      else if (ar_c >= ar_dly) arready = 1; else ar_c++;
      if (!rready) begin rvalid = 0; r_c = 0; end
      else if (r_c >= r_dly) rvalid = 1; else r_c++;
      if (!awvalid) begin awready = 0; aw_c = 0; end
      else if (aw_c >= aw_dly) awready = 1; else aw_c++;
      if (!wvalid) begin wready = 0; w_c = 0; end
      else if (w_c >= w_dly) wready = 1; else w_c++;
      if (!bready) begin bvalid = 0; b_c = 0; end
      else if (b_c >= b_dly) bvalid = 1; else b_c++;
    end
  end

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkValue("idle_activity", {28'd0, done, arvalid, awvalid, wvalid}, 32'd0);
      return;
    end
    e = sb_q[0];
    if (arvalid) begin
      checkValue("arvalid_allowed", (e.bus == 1) ? 32'd1 : 32'd0, 32'd1);
      checkValue("araddr", araddr, e.addr);
    end
    if (awvalid) begin
      checkValue("awvalid_allowed", (e.bus == 2) ? 32'd1 : 32'd0, 32'd1);
      checkValue("awaddr", awaddr, e.addr);
    end
    if (wvalid) begin
      checkValue("wvalid_allowed", (e.bus == 2) ? 32'd1 : 32'd0, 32'd1);
      checkValue("wdata", wdata, e.wdata);
      checkValue("wstrb", {28'd0, wstrb}, {28'd0, e.wstrb});
    end
    if (done) begin
      checkValue("mem_r", mem_r, e.mem);
      checkValue("err", {31'd0, err}, {31'd0, e.err});
      if (e.lat != 0) checkValue("latency", cyc - accept_cyc, e.lat);
      void'(sb_q.pop_front());
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) checkOutput();
    end
  end

  task automatic startReq(input vec_t v);
    exp_t e;
    ar_dly = v.ar_d; r_dly = v.r_d; aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d;
    rdata_val = v.rd; rresp_val = v.rr; bresp_val = v.br;
    e.mem = v.exp_mem; e.err = v.exp_err; e.lat = v.exp_lat; e.bus = v.exp_bus;
    e.addr = v.exp_addr; e.wdata = v.exp_wdata; e.wstrb = v.exp_wstrb;
    sb_q.push_back(e);
    req_valid = 1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
    addr = v.a; st_data = v.sd;
    @(posedge clk);
    accept_cyc = cyc;
    @(negedge clk);
    req_valid = 0; is_load = 0; is_store = 0; funct3 = '0; addr = '0; st_data = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      checkValue("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    startReq(v);
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
    if (sb_q.size() != 0) begin
      checkValue("done_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  initial begin : stim
    int guard;
    checks = 0; errors = 0; cyc = 0; accept_cyc = 0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    rdata_val = '0; rresp_val = '0; bresp_val = '0;
    req_valid = 0; is_load = 0; is_store = 0; funct3 = '0; addr = '0; st_data = '0;

    //            ld st f3      addr          st_data       rdata         rr     br     ar r aw w b  exp_mem       err lat bus exp_addr      exp_wdata     strb
    vecs.push_back(mk(1, 0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_1234, 2'd0, 2'd0, 0, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 3, 1, 32'h8000_0000, 32'h0, 4'h0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'hBEEF_0000, 2'd0, 2'd0, 2, 3, 0, 0, 0, 32'h0000_BEEF, 0, 0, 1, 32'h0000_0100, 32'h0, 4'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0206, 32'h0000_ABCD, 32'h0,        2'd0, 2'd0, 0, 0, 0, 2, 1, 32'h0000_BEEF, 0, 0, 2, 32'h0000_0204, 32'hABCD_0000, 4'hC));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0206, 32'h0000_ABCD, 32'h0,        2'd0, 2'd0, 0, 0, 2, 0, 2, 32'h0000_BEEF, 0, 0, 2, 32'h0000_0204, 32'hABCD_0000, 4'hC));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0,        2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h0000_BEEF, 0, 3, 2, 32'h0000_0300, 32'h1234_5678, 4'hF));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h0000_BEEF, 1, 1, 0, 32'h0,         32'h0, 4'h0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        2'd0, 2'd2, 0, 0, 0, 0, 0, 32'h0000_BEEF, 1, 3, 2, 32'h0000_0300, 32'hCAFE_F00D, 4'hF));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 2'd0, 2'd0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 3, 1, 32'h0000_0300, 32'h0, 4'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0040, 32'h0,        32'h0000_8001, 2'd0, 2'd0, 1, 0, 0, 0, 0, 32'hFFFF_8001, 0, 0, 1, 32'h0000_0040, 32'h0, 4'h0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_0041, 32'h0,        32'h0000_F700, 2'd0, 2'd0, 0, 1, 0, 0, 0, 32'h0000_00F7, 0, 0, 1, 32'h0000_0040, 32'h0, 4'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0010, 32'h0,        32'h1111_2222, 2'd2, 2'd0, 0, 0, 0, 0, 0, 32'h1111_2222, 1, 3, 1, 32'h0000_0010, 32'h0, 4'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0013, 32'h0000_00AB, 32'h0,        2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h1111_2222, 0, 3, 2, 32'h0000_0010, 32'hAB00_0000, 4'h8));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h1111_2222, 1, 1, 0, 32'h0,         32'h0, 4'h0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h1111_2222, 1, 1, 0, 32'h0,         32'h0, 4'h0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h1111_2222, 1, 1, 0, 32'h0,         32'h0, 4'h0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h1111_2222, 1, 1, 0, 32'h0,         32'h0, 4'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0201, 32'h0,        32'h0,        2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h1111_2222, 1, 1, 0, 32'h0,         32'h0, 4'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0002, 32'h0,        32'h0042_0000, 2'd0, 2'd0, 0, 0, 0, 0, 0, 32'h0000_0042, 0, 3, 1, 32'h0000_0000, 32'h0, 4'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0002, 32'h0000_1234, 32'h0,        2'd0, 2'd0, 0, 0, 1, 1, 2, 32'h0000_0042, 0, 0, 2, 32'h0000_0000, 32'h1234_0000, 4'hC));

    // Reset state while rst is held.
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    checkValue("reset_req_ready", {31'd0, req_ready}, 32'd1);
    checkValue("reset_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, done}, 32'd0);
    checkValue("reset_err", {31'd0, err}, 32'd0);
    checkValue("reset_mem_r", mem_r, 32'd0);
    @(negedge clk);
    rst = 0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset while waiting in R: everything drops at once, no done follows.
    @(negedge clk);
    startReq(mk(1, 0, 3'b101, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 2'd0, 2'd0,
                0, 10, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0000_0100, 32'h0, 4'h0));
    guard = 0;
    while (!rready && guard < 20) begin @(negedge clk); guard++; end
    checkValue("reached_r", {31'd0, rready}, 32'd1);
    #2 rst = 1;
    #1;
    checkValue("rst_async_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, done}, 32'd0);
    checkValue("rst_async_req_ready", {31'd0, req_ready}, 32'd1);
    checkValue("rst_async_mem_r", mem_r, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    applyStimulus(mk(1, 0, 3'b010, 32'h0000_0008, 32'h0, 32'h5A5A_5A5A, 2'd0, 2'd0,
                     0, 0, 0, 0, 0, 32'h5A5A_5A5A, 0, 3, 1, 32'h0000_0008, 32'h0, 4'h0));
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
Load/store unit that turns one decoded memory instruction into AXI4-Lite-style master transactions and returns the aligned, extended load word to writeback as mem_r. It sits between the execute stage, which supplies the ALU address and the store data, and the data-memory bus. It handles one request at a time. Sub-word loads are extended here; stores get byte strobes here.

Parameters:
ISA_WIDTH, 32, data and address width; the byte-lane logic is fixed at 4 lanes.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  execute stage presents a request
req_ready  out  1  high only in IDLE
is_load  in  1  request is a load
is_store  in  1  request is a store
funct3  in  3  access size and sign
addr  in  ISA_WIDTH  byte address (alu_result)
st_data  in  ISA_WIDTH  store data (rs2), right-aligned
done  out  1  one-cycle pulse: request finished
err  out  1  sticky per-request error, valid with done
mem_r  out  ISA_WIDTH  extended load result, held until the next load completes
araddr  out  ISA_WIDTH  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  ISA_WIDTH  read data
rresp  in  2  read response; non-zero means error
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ISA_WIDTH  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  ISA_WIDTH  lane-shifted store data
wstrb  out  4  byte strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response; non-zero means error
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All valid and ready outputs are 0, except req_ready=1.
  - done=0, err=0, mem_r=0.
  - Asserting rst mid-transaction abandons it immediately; no done pulse.
- States and transitions:
  - IDLE → AR on an accepted load.
  - IDLE → W on an accepted store.
  - IDLE → FIN on a faulted request.
  - AR → R on arvalid&arready.
  - R → FIN on rvalid&rready.
  - W → B once both AW and W have been accepted.
  - B → FIN on bvalid&bready.
  - FIN → IDLE, unconditionally.
- Acceptance: req_valid&req_ready in cycle T. The block registers addr, st_data, funct3 and the request kind. The bus valid is asserted in T+1.
- Fault, no bus traffic: the request goes straight to FIN with err=1 in any of these cases:
  - is_load and is_store are equal (both set or both clear);
  - an illegal funct3 (load: 011, 110, 111; store: anything above 010);
  - misalignment (half with addr[0]=1; word with addr[1:0]≠0).
- Loads:
  - araddr = addr with bits [1:0] forced to 0.
  - arvalid stays high until arready. rready is high only in R.
  - The byte or half is taken from rdata shifted right by 8*addr[1:0].
  - Extension by funct3: 000 lb sign, 001 lh sign, 010 lw, 100 lbu zero, 101 lhu zero.
- Stores:
  - awaddr = word-aligned addr.
  - wdata = st_data shifted left by 8*addr[1:0].
  - wstrb by size: sb 0001, sh 0011, sw 1111, each shifted left by addr[1:0].
  - awvalid and wvalid rise together in W. Each drops independently on its own handshake. Same-cycle and either-order acceptance must both work.
  - bready is high only in B.
- Completion (FIN):
  - done=1 for exactly one cycle.
  - For a load, mem_r is updated in that same FIN cycle from the registered read data.
  - err=1 if the request faulted or resp≠0.
  - An errored load still writes mem_r with the (garbage) extended data.
  - Stores and faulted requests leave mem_r unchanged.
- Latency: with a zero-wait slave, done is asserted in T+3 for both loads and stores.
- Throughput: a new request can be accepted in the cycle after FIN. req_ready=0 in every non-IDLE state.
- Stability: bus address, data and strobe outputs are constant while their valid is high.

Test Plan:
- lb from addr 0x8000_0003, rdata=0x80FF_1234, zero-wait slave → araddr=0x8000_0000; done at T+3; mem_r=0xFFFF_FF80; err=0.
- lhu from addr 0x102, rdata=0xBEEF_0000, with 2 cycles of arready delay and 3 cycles of rvalid delay → mem_r=0x0000_BEEF; done pulses exactly once.
- sh to 0x206 with st_data=0x0000_ABCD → awaddr=0x204, wdata=0xABCD_0000, wstrb=1100. Run once with awready before wready and once with the reverse order; done follows the bvalid handshake.
- lw to 0x101 (misaligned) → no arvalid ever; done at T+1 with err=1; mem_r unchanged.
- sw to 0x300 with bresp=2'b10 → done with err=1. An immediately following lw returns correct data with err=0.
- rst pulse while in R → all valids drop asynchronously; no done; req_ready=1 after release; the next load completes normally.
